dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-addressable data memory target.
// Serves CPU load/store requests over valid/ready request and response
// handshakes, with a programmable wait before each response.
//
// Ports:
//   clk_i, rst_i        clock, async active-low reset
//   req_valid_i/ready_o request handshake
//   req_addr_i          byte address
//   req_wdata_i         store data (low byte/half for narrow stores)
//   req_write_i         1 = store, 0 = load
//   req_width_i         00 byte, 01 half, 10 word, 11 reserved
//   req_sign_extend_i   sign-extend narrow loads
//   rsp_valid_o/ready_i response handshake
//   rsp_rdata_o         load data, 0 for stores and errors
//   rsp_error_o         access rejected
module dmem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic        req_write_i,
   input  logic [1:0]  req_width_i,
   input  logic        req_sign_extend_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_error_o
);

   localparam int         DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [3:0] LAT    = LATENCY[3:0];
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [1:0]  width_q, width_d;
   logic        sext_q, sext_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [7:0]  mem_q [DEPTH];

   logic        enter_resp;
   logic        idle;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_write;
   logic [1:0]  acc_width;
   logic        acc_sext;
   logic        acc_err;
   logic        misal;
   logic        oor;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [31:0] rd_word;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_data;
   logic [3:0]  wen;
   logic [31:0] wlane;
   logic        mem_we;

   assign idle        = (state_q == S_IDLE);
   assign req_ready_o = idle;
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_error_o = error_q;

   // With zero latency the access happens on the accept edge itself,
   // before the request is latched, so use the live inputs in IDLE.
   assign acc_addr  = idle ? req_addr_i        : addr_q;
   assign acc_wdata = idle ? req_wdata_i       : wdata_q;
   assign acc_write = idle ? req_write_i       : write_q;
   assign acc_width = idle ? req_width_i       : width_q;
   assign acc_sext  = idle ? req_sign_extend_i : sext_q;

   assign word_idx = acc_addr[ADDR_WIDTH-1:2];
   assign oor      = |(acc_addr >> ADDR_WIDTH);
   assign acc_err  = oor | misal;
   assign mem_we   = enter_resp & acc_write & ~acc_err;

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         rd_word[8*k +: 8] = mem_q[{word_idx, 2'(k)}];
      end
   end

   always_comb begin
      byte_v = rd_word[7:0];
      unique case (acc_addr[1:0])
         2'd0: byte_v = rd_word[7:0];
         2'd1: byte_v = rd_word[15:8];
         2'd2: byte_v = rd_word[23:16];
         2'd3: byte_v = rd_word[31:24];
         default: byte_v = rd_word[7:0];
      endcase
      half_v = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      misal     = 1'b1;
      wen       = 4'b0000;
      wlane     = '0;
      load_data = '0;
      unique case (acc_width)
         2'b00: begin
            misal     = 1'b0;
            wen       = 4'b0001 << acc_addr[1:0];
            wlane     = {4{acc_wdata[7:0]}};
            load_data = {{24{acc_sext & byte_v[7]}}, byte_v};
         end
         2'b01: begin
            misal     = acc_addr[0];
            wen       = acc_addr[1] ? 4'b1100 : 4'b0011;
            wlane     = {2{acc_wdata[15:0]}};
            load_data = {{16{acc_sext & half_v[15]}}, half_v};
         end
         2'b10: begin
            misal     = |acc_addr[1:0];
            wen       = 4'b1111;
            wlane     = acc_wdata;
            load_data = rd_word;
         end
         default: begin
            misal = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      width_d    = width_q;
      sext_d     = sext_q;
      rdata_d    = rdata_q;
      error_d    = error_q;
      enter_resp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               write_d = req_write_i;
               width_d = req_width_i;
               sext_d  = req_sign_extend_i;
               cnt_d   = LAT;
               if (LAT == 4'd0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (enter_resp) begin
         error_d = acc_err;
         rdata_d = (acc_err | acc_write) ? 32'h0 : load_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         width_q <= 2'b00;
         sext_q  <= 1'b0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         width_q <= width_d;
         sext_q  <= sext_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Storage is never reset; the rst_i gate keeps a zero-latency
   // request seen during reset from committing.
   always_ff @(posedge clk_i) begin
      if (rst_i && mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (wen[k]) begin
               mem_q[{word_idx, 2'(k)}] <= wlane[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder.
// Drives a LATENCY=2 and a LATENCY=0 instance side by side.
module tb_dmem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        req_write [2];
   logic [1:0]  req_width [2];
   logic        req_sx    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_error [2];

   int errors = 0;
   int checks = 0;

   logic [7:0] ref_mem [2][1024];

   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
      .clk_i(clk), .rst_i(rst[0]),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
      .req_write_i(req_write[0]), .req_width_i(req_width[0]),
      .req_sign_extend_i(req_sx[0]),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0])
   );

   dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst[1]),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
      .req_write_i(req_write[1]), .req_width_i(req_width[1]),
      .req_sign_extend_i(req_sx[1]),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1])
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic        wr;
      logic [1:0]  w;
      logic        sx;
      logic        e;
      logic [31:0] rd;
   } vec_t;

   // Reference: byte-array memory, little-endian, rules applied directly.
   function automatic logic [32:0] model(
      input int s, input logic [31:0] a, input logic [31:0] wd,
      input logic wr, input logic [1:0] w, input logic sx);
      int     nb;
      longint v;
      nb = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      if (w == 2'd3 || (a % nb) != 0 || a >= 1024)
         return {1'b1, 32'h0};
      if (wr) begin
         for (int i = 0; i < nb; i++)
            ref_mem[s][a + i] = wd[8*i +: 8];
         return 33'h0;
      end
      v = 0;
      for (int i = 0; i < nb; i++)
         v += longint'(ref_mem[s][a + i]) << (8 * i);
      if (sx && nb < 4 && v[8*nb-1])
         v = v - (longint'(1) << (8 * nb));
      return {1'b0, v[31:0]};
   endfunction

   task automatic xact(
      input int s, input logic [31:0] a, input logic [31:0] wd,
      input logic wr, input logic [1:0] w, input logic sx,
      output logic e, output logic [31:0] rd, output int lat);
      int n = 0;
      e = 1'b0; rd = 32'h0; lat = 0;
      while (!req_ready[s] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!req_ready[s]) begin
         checks++; errors++;
         $display("FAIL xact_ready dut%0d: ready=0 required 1", s);
         return;
      end
      req_addr[s] = a; req_wdata[s] = wd; req_write[s] = wr;
      req_width[s] = w; req_sx[s] = sx; req_valid[s] = 1'b1;
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
      req_addr[s] = $urandom; req_wdata[s] = $urandom;
      req_write[s] = 1'($urandom); req_width[s] = 2'($urandom);
      req_sx[s] = 1'($urandom);
      lat = 1;
      while (!rsp_valid[s] && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid[s]) begin
         checks++; errors++;
         $display("FAIL xact_rsp dut%0d: no rsp_valid in %0d", s, lat);
         return;
      end
      e = rsp_error[s];
      rd = rsp_rdata[s];
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         checks++;
         if ({req_ready[s], rsp_valid[s], rsp_error[s], rsp_rdata[s]}
             !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset dut%0d: rdy=%b vld=%b err=%b rd=%h",
                     s, req_ready[s], rsp_valid[s], rsp_error[s],
                     rsp_rdata[s]);
         end
      end
   endtask

   task automatic test_directed();
      vec_t tab[$];
      logic e; logic [31:0] rd; int lat;
      tab.push_back('{32'h010, 32'hDEADBEEF, 1, 2'd2, 0, 0, 32'h0});
      tab.push_back('{32'h010, 32'h0, 0, 2'd2, 0, 0, 32'hDEADBEEF});
      tab.push_back('{32'h011, 32'h0, 0, 2'd0, 1, 0, 32'hFFFFFFBE});
      tab.push_back('{32'h011, 32'h0, 0, 2'd0, 0, 0, 32'h000000BE});
      tab.push_back('{32'h012, 32'h0, 0, 2'd1, 1, 0, 32'hFFFFDEAD});
      tab.push_back('{32'h013, 32'hAAAAAA55, 1, 2'd0, 0, 0, 32'h0});
      tab.push_back('{32'h010, 32'h0, 0, 2'd2, 1, 0, 32'h55ADBEEF});
      tab.push_back('{32'h012, 32'h12345678, 1, 2'd2, 0, 1, 32'h0});
      tab.push_back('{32'h010, 32'h0, 0, 2'd2, 0, 0, 32'h55ADBEEF});
      tab.push_back('{32'h010, 32'h0, 0, 2'd3, 0, 1, 32'h0});
      tab.push_back('{32'h400, 32'h11111111, 1, 2'd2, 0, 1, 32'h0});
      tab.push_back('{32'h80000010, 32'h0, 0, 2'd2, 0, 1, 32'h0});
      tab.push_back('{32'h011, 32'h0, 0, 2'd1, 0, 1, 32'h0});
      tab.push_back('{32'h016, 32'hFFFF8001, 1, 2'd1, 0, 0, 32'h0});
      tab.push_back('{32'h016, 32'h0, 0, 2'd1, 0, 0, 32'h00008001});
      tab.push_back('{32'h016, 32'h0, 0, 2'd1, 1, 0, 32'hFFFF8001});
      tab.push_back('{32'h017, 32'h0, 0, 2'd0, 1, 0, 32'hFFFFFF80});
      tab.push_back('{32'h010, 32'h0, 0, 2'd2, 0, 0, 32'h55ADBEEF});
      foreach (tab[i]) begin
         xact(0, tab[i].a, tab[i].wd, tab[i].wr, tab[i].w, tab[i].sx,
              e, rd, lat);
         checks++;
         if ({e, rd} !== {tab[i].e, tab[i].rd} || lat != 3) begin
            errors++;
            $display("FAIL directed[%0d]: err=%b rd=%h lat=%0d req %b %h 3",
                     i, e, rd, lat, tab[i].e, tab[i].rd);
         end
      end
   endtask

   task automatic test_random();
      logic e; logic [31:0] rd; int lat;
      logic [32:0] exp;
      logic [31:0] a, wd;
      logic wr, sx;
      logic [1:0] w;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) begin
            a = 32'h100 + 32'(4 * i);
            wd = $urandom;
            exp = model(s, a, wd, 1'b1, 2'd2, 1'b0);
            xact(s, a, wd, 1'b1, 2'd2, 1'b0, e, rd, lat);
            checks++;
            if ({e, rd} !== exp) begin
               errors++;
               $display("FAIL init dut%0d @%h: %b/%h req %b/%h",
                        s, a, e, rd, exp[32], exp[31:0]);
            end
         end
         for (int i = 0; i < 64; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
            wd = $urandom;
            wr = 1'($urandom);
            w = 2'($urandom);
            sx = 1'($urandom);
            exp = model(s, a, wd, wr, w, sx);
            xact(s, a, wd, wr, w, sx, e, rd, lat);
            checks++;
            if ({e, rd} !== exp || lat != (s == 0 ? 3 : 1)) begin
               errors++;
               $display("FAIL rand dut%0d %h w%0d wr%b: %b/%h lat%0d req %b/%h",
                        s, a, w, wr, e, rd, lat, exp[32], exp[31:0]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic e; logic [31:0] rd; int lat; int n;
      rsp_ready[0] = 1'b0;
      xact(0, 32'h010, 32'h0, 1'b0, 2'd2, 1'b0, e, rd, lat);
      checks++;
      if ({e, rd} !== {1'b0, 32'h55ADBEEF}) begin
         errors++;
         $display("FAIL bp_first: %b/%h req 0/55adbeef", e, rd);
      end
      req_addr[0] = 32'h010; req_width[0] = 2'd0; req_write[0] = 1'b0;
      req_sx[0] = 1'b0; req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({rsp_valid[0], req_ready[0], rsp_rdata[0]}
             !== {1'b1, 1'b0, 32'h55ADBEEF}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b rd=%h req 1 0 55adbeef",
                     i, rsp_valid[0], req_ready[0], rsp_rdata[0]);
         end
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: vld=%b rdy=%b req 0 1",
                  rsp_valid[0], req_ready[0]);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      n = 1;
      while (!rsp_valid[0] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if ({rsp_valid[0], rsp_error[0], rsp_rdata[0], n}
          !== {1'b1, 1'b0, 32'h000000EF, 32'd3}) begin
         errors++;
         $display("FAIL bp_next: vld=%b err=%b rd=%h lat=%0d req 1 0 ef 3",
                  rsp_valid[0], rsp_error[0], rsp_rdata[0], n);
      end
   endtask

   task automatic test_reset_mid();
      logic e; logic [31:0] rd; int lat; int n = 0;
      xact(0, 32'h020, 32'h0, 1'b1, 2'd2, 1'b0, e, rd, lat);
      xact(0, 32'h010, 32'h0, 1'b0, 2'd2, 1'b0, e, rd, lat);
      checks++;
      if ({e, rd} !== {1'b0, 32'h55ADBEEF}) begin
         errors++;
         $display("FAIL rm_pre: %b/%h req 0/55adbeef", e, rd);
      end
      while (!req_ready[0] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      req_addr[0] = 32'h020; req_wdata[0] = 32'hFFFFFFFF;
      req_write[0] = 1'b1; req_width[0] = 2'd2; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rst[0] = 1'b0;
      #1;
      checks++;
      if ({req_ready[0], rsp_valid[0], rsp_error[0], rsp_rdata[0]}
          !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL rm_reset: rdy=%b vld=%b err=%b rd=%h req 1 0 0 0",
                  req_ready[0], rsp_valid[0], rsp_error[0], rsp_rdata[0]);
      end
      repeat (2) @(posedge clk);
      #1 rst[0] = 1'b1;
      xact(0, 32'h020, 32'h0, 1'b0, 2'd2, 1'b0, e, rd, lat);
      checks++;
      if ({e, rd} !== 33'h0) begin
         errors++;
         $display("FAIL rm_after: %b/%h req 0/00000000", e, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic e; logic [31:0] rd; int lat; int n = 0;
      logic exp_v;
      xact(1, 32'h040, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, e, rd, lat);
      checks++;
      if ({e, rd} !== 33'h0 || lat != 1) begin
         errors++;
         $display("FAIL b2b_store: %b/%h lat=%0d req 0/0 1", e, rd, lat);
      end
      while (!req_ready[1] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      req_addr[1] = 32'h040; req_write[1] = 1'b0;
      req_width[1] = 2'd2; req_valid[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         exp_v = (i % 2 == 0);
         checks++;
         if (rsp_valid[1] !== exp_v || req_ready[1] !== !exp_v ||
             (exp_v && rsp_rdata[1] !== 32'hCAFEF00D)) begin
            errors++;
            $display("FAIL b2b[%0d]: vld=%b rdy=%b rd=%h req vld=%b",
                     i, rsp_valid[1], req_ready[1], rsp_rdata[1], exp_v);
         end
      end
      req_valid[1] = 1'b0;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; req_valid[s] = 1'b0; req_addr[s] = '0;
         req_wdata[s] = '0; req_write[s] = 1'b0; req_width[s] = 2'd0;
         req_sx[s] = 1'b0; rsp_ready[s] = 1'b1;
      end
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(posedge clk); #1;
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

endmodule
